// File: rtl/half_to_full_cdc.sv
// Half-rate to full-rate stream converter: phase-qualified input side, small FIFO,
// full-rate output side, plus a sticky flag for upstream data not held across a pair.
module half_to_full_cdc #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             half_clock,
  input  logic [WIDTH-1:0] t0_data,
  input  logic             t0_valid,
  output logic             t0_ready,
  output logic [WIDTH-1:0] i0_data,
  output logic             i0_valid,
  input  logic             i0_ready,
  output logic             phase_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             push;
  logic             pop;

  assign push     = half_clock & t0_valid & t0_ready;
  assign pop      = i0_valid & i0_ready;
  assign i0_valid = (count != '0);
  assign i0_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  // t0_ready only moves on phase edges, so between updates only pops can happen
  // and a push can never land on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      t0_ready  <= 1'b0;
      phase_err <= 1'b0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        mem[wr_ptr] <= t0_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (half_clock) begin
        t0_ready <= (count_nxt < DEPTH_C);
        if (t0_valid && (!cap_valid || (cap_data != t0_data)))
          phase_err <= 1'b1;
      end else begin
        cap_data  <= t0_data;
        cap_valid <= t0_valid;
      end
    end
  end

endmodule
